// File: rtl/video_scandbl_pkg.sv
// Shared constants, pixel layout and mode encoding for the scan doubler.
// Latency n/a; no backpressure.
package video_scandbl_pkg;

  localparam int HACTIVE_DEF = 360;
  localparam int PIPE_DEPTH  = 2;
  localparam int PIX_W       = 15;

  localparam int R_MSB = 14;
  localparam int R_LSB = 10;
  localparam int G_MSB = 9;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [R_MSB-R_LSB:0] r;
    logic [G_MSB-G_LSB:0] g;
    logic [B_MSB-B_LSB:0] b;
  } rgb555_t;

  typedef enum logic {
    MODE_TV  = 1'b0,
    MODE_VGA = 1'b1
  } mode_e;

  // Scanline dimming: halve each channel independently.
  function automatic rgb555_t rgb_dim(input rgb555_t p);
    rgb555_t q;
    q.r = p.r >> 1;
    q.g = p.g >> 1;
    q.b = p.b >> 1;
    return q;
  endfunction

endpackage

// File: rtl/video_scandbl_if.sv
// Strobe, counter and pixel bundle between the video timing/renderer and the scan doubler.
// Latency n/a; no backpressure (strobe driven).
interface video_scandbl_if;
  import video_scandbl_pkg::*;

  logic             c3;
  logic             f1;
  logic             frame_start;
  logic             vga_on_req;
  logic             scanl_req;
  logic [9:0]       vga_cnt_in;
  logic [9:0]       vga_cnt_out;
  logic             tv_blank;
  logic             vga_blank;
  logic             vga_line;
  logic [PIX_W-1:0] pix_in;
  logic [PIX_W-1:0] pix_out;
  logic             blank_out;
  logic             vga_mode;
  logic             ovf;

  modport master (
    output c3, f1, frame_start, vga_on_req, scanl_req, vga_cnt_in, vga_cnt_out,
           tv_blank, vga_blank, vga_line, pix_in,
    input  pix_out, blank_out, vga_mode, ovf
  );

  modport slave (
    input  c3, f1, frame_start, vga_on_req, scanl_req, vga_cnt_in, vga_cnt_out,
           tv_blank, vga_blank, vga_line, pix_in,
    output pix_out, blank_out, vga_mode, ovf
  );

endinterface

// File: rtl/video_linebuf.sv
// Simple dual-port line buffer, read-before-write on address collision.
// Latency 1 clk on the read port; no backpressure.
module video_linebuf
  import video_scandbl_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = PIX_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [2**AW];

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/video_scandbl.sv
// TV-to-VGA scan doubler: lines written at c3, each read twice at f1, optional scanline dimming.
// Latency 2 clk from the issuing strobe to pix_out/blank_out; no backpressure.
module video_scandbl
  import video_scandbl_pkg::*;
#(
  parameter int LB_AW   = 10,
  parameter int HACTIVE = HACTIVE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  video_scandbl_if.slave  bus
);

  localparam int                CW   = LB_AW - 1;
  localparam logic [CW-1:0]     HMAX = CW'(HACTIVE);

  mode_e   mode_q, mode_d;
  logic    scanl_act;
  logic    ovf;

  logic    wr_hit, wr_drop, rd_in_rng, rd_hit;
  rgb555_t rd_dat;

  logic    vga_s1_vld, vga_s1_zero, vga_s1_line, vga_s1_blank;
  logic    tv_s1_vld, tv_s1_blank;
  rgb555_t tv_s1_dat;
  rgb555_t vga_pix;
  rgb555_t pix_q;
  logic    blank_q;

  assign wr_hit    = bus.c3 && !bus.tv_blank && (bus.vga_cnt_in[CW-1:0] <  HMAX);
  assign wr_drop   = bus.c3 && !bus.tv_blank && (bus.vga_cnt_in[CW-1:0] >= HMAX);
  assign rd_in_rng = bus.vga_cnt_out[CW-1:0] < HMAX;
  assign rd_hit    = bus.f1 && rd_in_rng;

  video_linebuf #(.AW(LB_AW), .DW(PIX_W)) u_linebuf (
    .clk     (clk),
    .wr_en   (wr_hit),
    .wr_addr (bus.vga_cnt_in[LB_AW-1:0]),
    .wr_dat  (bus.pix_in),
    .rd_en   (rd_hit),
    .rd_addr (bus.vga_cnt_out[LB_AW-1:0]),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) mode_q <= MODE_TV;
    else        mode_q <= mode_d;
  end

  // Mode only changes on the frame boundary so a frame is never split.
  always_comb begin
    mode_d = mode_q;
    if (bus.frame_start && bus.c3) begin
      if (bus.vga_on_req) mode_d = MODE_VGA;
      else                mode_d = MODE_TV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scanl_act <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (bus.frame_start && bus.c3) scanl_act <= bus.scanl_req;
      if (wr_drop)                   ovf       <= 1'b1;
    end
  end

  // First stage: sideband aligned with the RAM read, TV pixel captured on c3.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_s1_vld   <= 1'b0;
      vga_s1_zero  <= 1'b0;
      vga_s1_line  <= 1'b0;
      vga_s1_blank <= 1'b1;
      tv_s1_vld    <= 1'b0;
      tv_s1_dat    <= '0;
      tv_s1_blank  <= 1'b1;
    end else begin
      vga_s1_vld <= bus.f1;
      tv_s1_vld  <= bus.c3;
      if (bus.f1) begin
        vga_s1_zero  <= !rd_in_rng;
        vga_s1_line  <= bus.vga_line;
        vga_s1_blank <= bus.vga_blank;
      end
      if (bus.c3) begin
        tv_s1_dat   <= bus.pix_in;
        tv_s1_blank <= bus.tv_blank;
      end
    end
  end

  always_comb begin
    vga_pix = rd_dat;
    if (vga_s1_zero)                     vga_pix = '0;
    else if (scanl_act && vga_s1_line)   vga_pix = rgb_dim(rd_dat);
  end

  // Output stage holds its value between strobes of the active mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q   <= '0;
      blank_q <= 1'b1;
    end else if (mode_q == MODE_VGA && vga_s1_vld) begin
      blank_q <= vga_s1_blank;
      if (vga_s1_blank) pix_q <= '0;
      else              pix_q <= vga_pix;
    end else if (mode_q == MODE_TV && tv_s1_vld) begin
      blank_q <= tv_s1_blank;
      if (tv_s1_blank) pix_q <= '0;
      else             pix_q <= tv_s1_dat;
    end
  end

  assign bus.pix_out   = pix_q;
  assign bus.blank_out = blank_q;
  assign bus.vga_mode  = (mode_q == MODE_VGA);
  assign bus.ovf       = ovf;

endmodule

// File: tb/tb_video_scandbl.sv
// Randomized bench for video_scandbl against a behavioural line-memory model.
`timescale 1ns/1ps
module tb_video_scandbl;
  import video_scandbl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_scandbl_if bus ();

  video_scandbl #(.LB_AW(10), .HACTIVE(HACTIVE_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [14:0] ref_mem   [1024];
  bit          ref_known [1024];
  bit          ref_ovf;
  bit          ref_scanl;
  logic [14:0] last_pix;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  function automatic logic [14:0] ref_dim(input logic [14:0] p);
    int r, g, b;
    r = int'(p) / 1024;
    g = (int'(p) / 32) % 32;
    b = int'(p) % 32;
    return 15'((r / 2) * 1024 + (g / 2) * 32 + (b / 2));
  endfunction

  function automatic logic [14:0] ref_vga(input int addr, input bit line, input bit blank);
    logic [14:0] v;
    if (blank || (addr % 512) >= HACTIVE_DEF) return 15'h0;
    v = ref_mem[addr];
    if (ref_scanl && line) v = ref_dim(v);
    return v;
  endfunction

  task automatic model_write(input int addr, input logic [14:0] p, input bit tvb);
    if (!tvb) begin
      if ((addr % 512) < HACTIVE_DEF) begin
        ref_mem[addr]   = p;
        ref_known[addr] = 1'b1;
      end else begin
        ref_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input logic [14:0] p, input bit tvb);
    bus.c3         = 1'b1;
    bus.vga_cnt_in = 10'(addr);
    bus.pix_in     = p;
    bus.tv_blank   = tvb;
    model_write(addr, p, tvb);
    tick();
    bus.c3 = 1'b0;
  endtask

  task automatic tv_pulse(input int addr, input logic [14:0] p, input bit tvb);
    logic [14:0] want;
    want = tvb ? 15'h0 : p;
    do_write(addr, p, tvb);
    check_eq("tv_early", 32'(bus.pix_out), 32'(last_pix));
    tick();
    check_eq("tv_pix", 32'(bus.pix_out), 32'(want));
    check_eq("tv_blank", 32'(bus.blank_out), 32'(tvb));
    last_pix = want;
  endtask

  task automatic vga_read(input string tag, input int addr, input bit line, input bit blank);
    logic [14:0] want;
    want = ref_vga(addr, line, blank);
    bus.f1          = 1'b1;
    bus.vga_cnt_out = 10'(addr);
    bus.vga_line    = line;
    bus.vga_blank   = blank;
    tick();
    bus.f1 = 1'b0;
    check_eq({tag, "_early"}, 32'(bus.pix_out), 32'(last_pix));
    tick();
    check_eq(tag, 32'(bus.pix_out), 32'(want));
    check_eq({tag, "_blank"}, 32'(bus.blank_out), 32'(blank));
    last_pix = want;
  endtask

  task automatic frame(input bit vga, input bit scl);
    bus.frame_start = 1'b1;
    bus.c3          = 1'b1;
    bus.vga_on_req  = vga;
    bus.scanl_req   = scl;
    bus.tv_blank    = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.c3          = 1'b0;
    check_eq("mode_next", 32'(bus.vga_mode), 32'(vga));
    ref_scanl = scl;
    tick();
    if (!vga) last_pix = 15'h0;
  endtask

  initial begin
    bus.c3 = 1'b0;          bus.f1 = 1'b0;          bus.frame_start = 1'b0;
    bus.vga_on_req = 1'b1;  bus.scanl_req = 1'b0;
    bus.vga_cnt_in = '0;    bus.vga_cnt_out = '0;
    bus.tv_blank = 1'b1;    bus.vga_blank = 1'b0;   bus.vga_line = 1'b0;
    bus.pix_in = '0;
    ref_ovf = 1'b0; ref_scanl = 1'b0; last_pix = 15'h0;

    // Reset, and no mode change without a frame boundary.
    rst_n = 1'b0;
    repeat (4) tick();
    check_eq("rst_pix", 32'(bus.pix_out), 32'h0);
    check_eq("rst_blank", 32'(bus.blank_out), 32'h1);
    check_eq("rst_mode", 32'(bus.vga_mode), 32'h0);
    rst_n = 1'b1;
    repeat (3) begin
      do_write(0, 15'h1111, 1'b1);
      tick();
    end
    check_eq("no_fs_mode", 32'(bus.vga_mode), 32'h0);
    check_eq("ovf_init", 32'(bus.ovf), 32'h0);

    // Mode switch, then a mid-frame request toggle must be ignored.
    frame(1'b1, 1'b0);
    bus.vga_on_req = 1'b0;
    do_write(0, 15'h0, 1'b1);
    tick();
    check_eq("mid_toggle", 32'(bus.vga_mode), 32'h1);

    // Line doubling.
    for (int c = 0; c < 360; c++) do_write(c, 15'(c), 1'b0);
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 360; c++) vga_read("dbl", c, l[0], 1'b0);
    check_eq("ovf_clean", 32'(bus.ovf), 32'h0);

    // Scanline dimming.
    frame(1'b1, 1'b1);
    do_write(10, 15'h7FFF, 1'b0);
    vga_read("scl_h1", 10, 1'b0, 1'b0);
    check_eq("scl_7fff", 32'(bus.pix_out), 32'h7FFF);
    vga_read("scl_h2", 10, 1'b1, 1'b0);
    check_eq("scl_3def", 32'(bus.pix_out), 32'h3DEF);

    // Out-of-range columns.
    do_write(400, 15'h7ABC, 1'b0);
    check_eq("ovf_set", 32'(bus.ovf), 32'(ref_ovf));
    vga_read("nowrap40", 40, 1'b0, 1'b0);
    vga_read("nowrap144", 144, 1'b0, 1'b0);
    vga_read("oob380", 380, 1'b0, 1'b0);
    check_eq("oob_zero", 32'(bus.pix_out), 32'h0);
    vga_read("vblank", 20, 1'b0, 1'b1);

    // Same-clk read and write of one address returns the old word.
    do_write(5, 15'h1234, 1'b0);
    bus.c3 = 1'b1; bus.vga_cnt_in = 10'd5; bus.pix_in = 15'h0ABC; bus.tv_blank = 1'b0;
    bus.f1 = 1'b1; bus.vga_cnt_out = 10'd5; bus.vga_line = 1'b0; bus.vga_blank = 1'b0;
    tick();
    bus.c3 = 1'b0; bus.f1 = 1'b0;
    model_write(5, 15'h0ABC, 1'b0);
    tick();
    check_eq("collide_old", 32'(bus.pix_out), 32'h1234);
    last_pix = 15'h1234;
    vga_read("collide_new", 5, 1'b0, 1'b0);

    // TV passthrough; RAM still written on the other parity.
    frame(1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      tv_pulse(512 + int'($urandom_range(0, 359)), 15'($urandom), 1'($urandom_range(0, 3) == 0));

    // Random mix of writes and doubled reads in VGA mode.
    frame(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++) begin
      int a;
      a = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) begin
        do_write(a, 15'($urandom), 1'($urandom_range(0, 3) == 0));
      end else begin
        if (!ref_known[a] && (a % 512) < HACTIVE_DEF) a = a % 512;
        vga_read("rnd", a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      end
    end

    // Reset mid-line aborts the pipeline; RAM survives.
    bus.f1 = 1'b1; bus.vga_cnt_out = 10'd3; bus.vga_blank = 1'b0;
    tick();
    bus.f1 = 1'b0;
    rst_n = 1'b0;
    tick();
    check_eq("mrst_pix", 32'(bus.pix_out), 32'h0);
    check_eq("mrst_blank", 32'(bus.blank_out), 32'h1);
    check_eq("mrst_mode", 32'(bus.vga_mode), 32'h0);
    tick();
    rst_n = 1'b1;
    ref_ovf = 1'b0; ref_scanl = 1'b0; last_pix = 15'h0;
    check_eq("mrst_ovf", 32'(bus.ovf), 32'(ref_ovf));
    tv_pulse(512 + 7, 15'h2468, 1'b0);
    check_eq("mrst_tv", 32'(bus.vga_mode), 32'h0);
    frame(1'b1, 1'b0);
    vga_read("retain", 5, 1'b0, 1'b0);
    vga_read("retain2", 200, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
